// File: rtl/arm_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// bus widths and the full-word byte-enable constant.
package arm_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_F_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    // Forms the word-aligned memory address from a byte address.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: byte enables, replicated store data
// and zero-extended byte load data. Purely combinational.
module mem_lane_align
    import arm_mem_pkg::*;
(
    input  logic [1:0]        lane_lo,
    input  logic              byte_acc,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [7:0] rbyte_s;

    // Byte enables and store data replication.
    always_comb begin
        be        = BE_WORD;
        wdata_out = wdata_in;
        if (byte_acc) begin
            be        = 4'b0001 << lane_lo;
            wdata_out = {4{wdata_in[7:0]}};
        end else begin
            be        = BE_WORD;
            wdata_out = wdata_in;
        end
    end

    // Load data lane select; word loads pass through unrotated.
    always_comb begin
        rbyte_s = 8'h00;
        case (lane_lo)
            2'd0:    rbyte_s = rdata_in[7:0];
            2'd1:    rbyte_s = rdata_in[15:8];
            2'd2:    rbyte_s = rdata_in[23:16];
            2'd3:    rbyte_s = rdata_in[31:24];
            default: rbyte_s = 8'h00;
        endcase
        if (byte_acc) begin
            rdata_out = {24'h000000, rbyte_s};
        end else begin
            rdata_out = rdata_in;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// favouring data but forcing a fetch after STARVE_MAX consecutive data grants.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              f_ready_q, f_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        d_lo_q, d_lo_d;
    logic              d_byte_q, d_byte_d;

    logic              grant_f_s, grant_d_s;
    logic [1:0]        lane_lo_s;
    logic              lane_byte_s;
    logic [3:0]        lane_be_s;
    logic [DATA_W-1:0] lane_wdata_s, lane_rdata_s;

    // In IDLE the aligner looks at the live request; in BUSY at the latched one.
    always_comb begin
        if (state_q == ST_IDLE) begin
            lane_lo_s   = d_addr[1:0];
            lane_byte_s = d_byte;
        end else begin
            lane_lo_s   = d_lo_q;
            lane_byte_s = d_byte_q;
        end
    end

    mem_lane_align u_align (
        .lane_lo   (lane_lo_s),
        .byte_acc  (lane_byte_s),
        .wdata_in  (d_wdata),
        .rdata_in  (mem_rdata),
        .be        (lane_be_s),
        .wdata_out (lane_wdata_s),
        .rdata_out (lane_rdata_s)
    );

    // Next-state, starvation counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        f_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_lo_d      = d_lo_q;
        d_byte_d    = d_byte_q;
        grant_f_s   = f_req && (!d_req || (starve_q >= STARVE_LIM));
        grant_d_s   = d_req && !grant_f_s;

        case (state_q)
            ST_IDLE: begin
                if (grant_f_s) begin
                    state_d     = ST_F_BUSY;
                    starve_d    = 4'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = BE_WORD;
                    mem_addr_d  = word_addr(f_addr);
                    mem_wdata_d = 32'h0000_0000;
                end else if (grant_d_s) begin
                    state_d     = ST_D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = lane_be_s;
                    mem_addr_d  = word_addr(d_addr);
                    mem_wdata_d = lane_wdata_s;
                    d_lo_d      = d_addr[1:0];
                    d_byte_d    = d_byte;
                    if (!f_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q < STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_F_BUSY: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    f_rdata_d = mem_rdata;
                    f_ready_d = 1'b1;
                end else begin
                    state_d = ST_F_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = lane_rdata_s;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = ST_D_BUSY;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= 4'd0;
            f_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            f_rdata_q   <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            d_lo_q      <= 2'd0;
            d_byte_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            f_ready_q   <= f_ready_d;
            d_ready_q   <= d_ready_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_lo_q      <= d_lo_d;
            d_byte_q    <= d_byte_d;
        end
    end

    assign f_ready   = f_ready_q;
    assign f_rdata   = f_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test of mem_port_arbiter: fetch, byte/word data accesses,
// starvation bound, wait states, reset abort and stray acks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;
    logic        d_req, d_we, d_byte;
    logic [31:0] d_addr, d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (mem_req !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("req_wait", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic data_txn(input string tag, input logic we, input logic byt,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wd;
        tick();
        chk({tag, "_req"},  {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"},   {28'd0, mem_be}, {28'd0, exp_be});
        chk({tag, "_we"},   {31'd0, mem_we}, {31'd0, we});
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk({tag, "_rdy"},   {31'd0, d_ready}, 32'd1);
        chk({tag, "_rdata"}, d_rdata, exp_rd);
        chk({tag, "_reqlo"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_rdy_once"}, {31'd0, d_ready}, 32'd0);
    endtask

    logic [31:0] exp_ga [6];
    int          dcount;
    logic        fseen;

    initial begin
        rst = 1'b1; f_req = 1'b0; f_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_byte = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_f_ready", {31'd0, f_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_be",  {28'd0, mem_be}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);

        // single fetch, zero wait
        f_req = 1'b1; f_addr = 32'h0000_0104;
        tick();
        chk("f_req_hi", {31'd0, mem_req}, 32'd1);
        chk("f_addr",   mem_addr, 32'h0000_0104);
        chk("f_be",     {28'd0, mem_be}, 32'hF);
        chk("f_we",     {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hE3A0_0001;
        tick();
        mem_ack = 1'b0; f_req = 1'b0;
        chk("f_ready",  {31'd0, f_ready}, 32'd1);
        chk("f_rdata",  f_rdata, 32'hE3A0_0001);
        tick();
        chk("f_ready_once", {31'd0, f_ready}, 32'd0);

        // byte and word data accesses
        data_txn("strb",  1'b1, 1'b1, 32'h0000_0203, 32'h1234_56AB, 32'hDEAD_BEEF,
                 4'h8, 32'hABAB_ABAB, 32'h0000_0000);
        data_txn("ldrb2", 1'b0, 1'b1, 32'h0000_0202, 32'h0, 32'h1122_3344,
                 4'h4, 32'h0, 32'h0000_0022);
        data_txn("ldrb1", 1'b0, 1'b1, 32'h0000_0201, 32'h0, 32'h1122_3344,
                 4'h2, 32'h0, 32'h0000_0033);
        data_txn("str_w", 1'b1, 1'b0, 32'h0000_0302, 32'hCAFE_F00D, 32'h0,
                 4'hF, 32'hCAFE_F00D, 32'h0000_0033);
        data_txn("ldr_w", 1'b0, 1'b0, 32'h0000_0301, 32'h0, 32'h8765_4321,
                 4'hF, 32'h0, 32'h8765_4321);

        // both held: D D D D F D
        exp_ga[0] = 32'h500; exp_ga[1] = 32'h500; exp_ga[2] = 32'h500;
        exp_ga[3] = 32'h500; exp_ga[4] = 32'h400; exp_ga[5] = 32'h500;
        dcount = 0; fseen = 1'b0;
        f_req = 1'b1; f_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0500;
        for (int i = 0; i < 6; i++) begin
            wait_req();
            chk($sformatf("starve_grant%0d", i), mem_addr, exp_ga[i]);
            mem_ack = 1'b1; mem_rdata = 32'h1000 + i;
            tick();
            mem_ack = 1'b0;
            if (d_ready === 1'b1 && !fseen) dcount++;
            if (f_ready === 1'b1) fseen = 1'b1;
            chk($sformatf("starve_rdy%0d", i), {30'd0, f_ready, d_ready},
                (exp_ga[i] == 32'h400) ? 32'd2 : 32'd1);
            if (i == 5) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end
        chk("d_before_f", dcount, 32'd4);

        // five wait states; request dropped and address changed mid-BUSY
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0600;
        tick();
        d_req = 1'b0; d_addr = 32'h0000_0ABC;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ws_req%0d", i),  {31'd0, mem_req}, 32'd1);
            chk($sformatf("ws_addr%0d", i), mem_addr, 32'h0000_0600);
            chk($sformatf("ws_rdy%0d", i),  {31'd0, d_ready}, 32'd0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        mem_ack = 1'b0;
        chk("ws_ready", {31'd0, d_ready}, 32'd1);
        chk("ws_rdata", d_rdata, 32'h55AA_55AA);
        tick();
        chk("ws_ready_once", {31'd0, d_ready}, 32'd0);

        // reset during D_BUSY, then a stray ack
        d_req = 1'b1; d_addr = 32'h0000_0700;
        tick();
        chk("rb_busy", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rb_req_lo", {31'd0, mem_req}, 32'd0);
        chk("rb_rdata0", d_rdata, 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
        tick();
        mem_ack = 1'b0;
        chk("rb_no_rdy", {30'd0, f_ready, d_ready}, 32'd0);
        chk("rb_rdata",  d_rdata, 32'h0);
        chk("rb_req",    {31'd0, mem_req}, 32'd0);
        f_req = 1'b1; f_addr = 32'h0000_0802;
        tick();
        chk("rb_f_addr", mem_addr, 32'h0000_0800);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; f_req = 1'b0;
        chk("rb_f_ready", {31'd0, f_ready}, 32'd1);
        chk("rb_f_rdata", f_rdata, 32'h1234_5678);
        tick();

        // stray ack in IDLE
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("stray_rdy",  {30'd0, f_ready, d_ready}, 32'd0);
        chk("stray_req",  {31'd0, mem_req}, 32'd0);
        chk("stray_frd",  f_rdata, 32'h1234_5678);
        chk("stray_drd",  d_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
